// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencing: hazard stalls, branch flushes,
// memory waits, halt/drain/resume and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_use_id,
  input  logic             rs2_use_id,
  input  logic             cond_id,
  input  logic [4:0]       rd_ex,
  input  logic             regwrite_ex,
  input  logic             memtoreg_ex,
  input  logic             update_ex,
  input  logic             br_taken_ex,
  input  logic             mem_busy,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN, MEM_WAIT, DRAIN, HALTED
  } state_t;

  state_t          state_q, state_d;
  logic            ret_drain_q, ret_drain_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [TW-1:0]   tcnt_q;
  logic            lu, fh, drain_mode, drain_bub;
  logic            rs1_hit, rs2_hit;
  state_t          base;

  assign rs1_hit = rs1_use_id & (rs1_id == rd_ex);
  assign rs2_hit = rs2_use_id & (rs2_id == rd_ex);
  assign lu = memtoreg_ex & regwrite_ex & (rd_ex != 5'd31)
            & (rs1_hit | rs2_hit);
  assign fh = cond_id & update_ex;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    halted       = 1'b0;
    drain_bub    = 1'b0;
    state_d      = state_q;
    ret_drain_d  = ret_drain_q;
    dcnt_d       = dcnt_q;
    drain_mode   = 1'b0;
    unique case (state_q)
      RUN:      drain_mode = 1'b0;
      DRAIN:    drain_mode = 1'b1;
      MEM_WAIT: drain_mode = ret_drain_q;
      HALTED:   drain_mode = 1'b0;
    endcase
    base = drain_mode ? DRAIN : RUN;
    if (state_q == HALTED) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      halted      = 1'b1;
      if (resume) state_d = RUN;
    end else if (mem_busy) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      state_d      = MEM_WAIT;
      if (state_q != MEM_WAIT)
        ret_drain_d = (state_q == DRAIN);
    end else if (br_taken_ex) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = base;
    end else if (lu | fh) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = base;
    end else if (drain_mode) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      drain_bub   = 1'b1;
      if (dcnt_q == DW'(1)) begin
        state_d = HALTED;
      end else begin
        state_d = DRAIN;
        dcnt_d  = dcnt_q - 1'b1;
      end
    end else if (state_q == RUN && halt_req) begin
      // the entry cycle is the first of the DRAIN_CYCLES bubbles
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      drain_bub   = 1'b1;
      dcnt_d      = DW'(DRAIN_CYCLES - 1);
      state_d     = (DRAIN_CYCLES <= 1) ? HALTED : DRAIN;
    end else begin
      state_d = RUN;
    end
    if (!reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      halted       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      ret_drain_q <= 1'b0;
      dcnt_q      <= '0;
      tcnt_q      <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      ret_drain_q <= ret_drain_d;
      dcnt_q      <= dcnt_d;
      if (mem_busy) begin
        if (tcnt_q != TW'(MEM_TIMEOUT))
          tcnt_q <= tcnt_q + 1'b1;
        if (tcnt_q == TW'(MEM_TIMEOUT - 1))
          mem_timeout <= 1'b1;
      end else begin
        tcnt_q <= '0;
      end
      if (!pc_en && !drain_bub && stall_cnt != '1 &&
          (state_q == RUN || state_q == MEM_WAIT))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
